// File: rtl/c_mem_port_b_loader_pkg.sv
// Shared widths and FSM state encoding for the C_Memory port-B loader.
package c_mem_port_b_loader_pkg;

  localparam int C_ADDR_W = 10;
  localparam int C_DATA_W = 16;
  localparam int C_RD_LAT = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RX_LO   = 3'd1,
    ST_RX_HI   = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RD_ADDR = 3'd4,
    ST_RD_WAIT = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

endpackage

// File: rtl/c_mem_port_b_loader_byte_to_word_packer.sv
// Byte-stream handshake and little-endian packing of byte pairs into memory words.
module byte_to_word_packer
  import c_mem_port_b_loader_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic                in_ready,
  input  logic                hi_phase,
  input  logic [7:0]          in_data,
  output logic                byte_take,
  output logic                word_valid,
  output logic [C_DATA_W-1:0] word
);

  logic [7:0] lo_q;
  logic [7:0] lo_d;

  // The word is presented in the same cycle as the high-byte handshake so the
  // loader can register it straight onto the memory write bus.
  always_comb begin
    byte_take  = in_valid && in_ready;
    word_valid = byte_take && hi_phase;
    word       = {in_data, lo_q};
    lo_d       = lo_q;
    if (byte_take && !hi_phase) lo_d = in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lo_q <= '0;
    else        lo_q <= lo_d;
  end

endmodule

// File: rtl/c_mem_port_b_loader.sv
// Loads a byte stream into C_Memory through port B as 16-bit words, then reads
// the region back and compares running checksums.
module c_mem_port_b_loader
  import c_mem_port_b_loader_pkg::*;
#(
  parameter int ADDR_W = C_ADDR_W,
  parameter int DATA_W = C_DATA_W,
  parameter int RD_LAT = C_RD_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] addr_data,
  output logic [DATA_W-1:0] data_write_b,
  output logic              save_b,
  input  logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   wr_count
);

  localparam logic [7:0] LAT_LAST = 8'(RD_LAT - 1);

  state_e state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   num_q, num_d, idx_q, idx_d, wr_count_q, wr_count_d;
  logic [DATA_W-1:0] wsum_q, wsum_d, rsum_q, rsum_d;
  logic [DATA_W-1:0] data_write_b_q, data_write_b_d;
  logic [ADDR_W-1:0] addr_data_q, addr_data_d;
  logic [7:0]        lat_q, lat_d;
  logic in_ready_q, in_ready_d, save_b_q, save_b_d;
  logic busy_q, busy_d, done_q, done_d, pass_q, pass_d;

  logic              byte_take;
  logic              word_valid;
  logic [DATA_W-1:0] word;

  byte_to_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready_q),
    .hi_phase   (state_q == ST_RX_HI),
    .in_data    (in_data),
    .byte_take  (byte_take),
    .word_valid (word_valid),
    .word       (word)
  );

  // Outputs are registered from the next state, so the write bus is loaded on
  // the transition into WRITE and the read address on the transition into RD_ADDR.
  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    num_d          = num_q;
    idx_d          = idx_q;
    wr_count_d     = wr_count_q;
    wsum_d         = wsum_q;
    rsum_d         = rsum_q;
    lat_d          = lat_q;
    addr_data_d    = addr_data_q;
    data_write_b_d = data_write_b_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          base_d     = base_addr;
          num_d      = num_words;
          idx_d      = '0;
          wr_count_d = '0;
          wsum_d     = '0;
          rsum_d     = '0;
          state_d    = (num_words == '0) ? ST_DONE : ST_RX_LO;
        end
      end
      ST_RX_LO: begin
        if (byte_take) state_d = ST_RX_HI;
      end
      ST_RX_HI: begin
        if (word_valid) begin
          addr_data_d    = base_q + idx_q[ADDR_W-1:0];
          data_write_b_d = word;
          wsum_d         = wsum_q + word;
          idx_d          = idx_q + 1'b1;
          wr_count_d     = wr_count_q + 1'b1;
          state_d        = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (idx_q == num_q) begin
          idx_d       = '0;
          addr_data_d = base_q;
          state_d     = ST_RD_ADDR;
        end else begin
          state_d = ST_RX_LO;
        end
      end
      ST_RD_ADDR: begin
        lat_d   = '0;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (lat_q == LAT_LAST) begin
          rsum_d = rsum_q + out_data;
          idx_d  = idx_q + 1'b1;
          if (idx_d == num_q) begin
            state_d = ST_DONE;
          end else begin
            addr_data_d = base_q + idx_d[ADDR_W-1:0];
            state_d     = ST_RD_ADDR;
          end
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_RX_LO) || (state_d == ST_RX_HI);
    save_b_d   = (state_d == ST_WRITE);
    busy_d     = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d     = (state_d == ST_DONE);
    pass_d     = done_d && (wsum_d == rsum_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      base_q         <= '0;
      num_q          <= '0;
      idx_q          <= '0;
      wr_count_q     <= '0;
      wsum_q         <= '0;
      rsum_q         <= '0;
      lat_q          <= '0;
      addr_data_q    <= '0;
      data_write_b_q <= '0;
      in_ready_q     <= 1'b0;
      save_b_q       <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      num_q          <= num_d;
      idx_q          <= idx_d;
      wr_count_q     <= wr_count_d;
      wsum_q         <= wsum_d;
      rsum_q         <= rsum_d;
      lat_q          <= lat_d;
      addr_data_q    <= addr_data_d;
      data_write_b_q <= data_write_b_d;
      in_ready_q     <= in_ready_d;
      save_b_q       <= save_b_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      pass_q         <= pass_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign addr_data    = addr_data_q;
  assign data_write_b = data_write_b_q;
  assign save_b       = save_b_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign wr_count     = wr_count_q;

endmodule
